// File: rtl/reg_transport.sv
// reg_transport
// Register writeback transport type and port-count limits for the register file.
// reg_transport_t : {addr, value} pair carried from writeback to a write port
// MaxReadPorts    : largest supported read port count
// MaxWritePorts   : largest supported write port count
package reg_transport;

    import rv32_isa::*;

    localparam int MaxReadPorts  = 4;
    localparam int MaxWritePorts = 2;

    typedef struct packed {
        logic [RegAddrWidth-1:0] addr;
        logic [RegWidth-1:0]     value;
    } reg_transport_t;

endpackage : reg_transport

// File: rtl/rv32_isa.sv
// rv32_isa
// Architectural constants of the RV32 integer ISA shared across the core.
// RegWidth     : integer register data width
// RegAddrWidth : integer register index width
package rv32_isa;

    localparam int RegWidth     = 32;
    localparam int RegAddrWidth = 5;

endpackage : rv32_isa

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Holds one pending bit per architectural register and applies the
// flush > reserve > write-clear priority at every rising edge.
// Ports:
//   iClk         : clock
//   iRst         : asynchronous active-high reset, clears every bit
//   iFlush       : clear all pending bits, ignoring a same-cycle reserve
//   iRsvEn       : mark iRsvAddr as pending
//   iRsvAddr     : destination register being reserved
//   iClrMask     : one bit per register that has an enabled write this cycle
//   oPendingMask : current pending bits, bit 0 always 0
module reg_scoreboard #(
    parameter int N_REGS     = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iFlush,
    input  logic                  iRsvEn,
    input  logic [ADDR_WIDTH-1:0] iRsvAddr,
    input  logic [N_REGS-1:0]     iClrMask,
    output logic [N_REGS-1:0]     oPendingMask
);

    logic [N_REGS-1:0] pending;
    logic [N_REGS-1:0] pendingNext;

    // Next pending state. A reserve beats a write-clear on the same register
    // because the newly issued instruction is now the owner of that register.
    // x0 can never have a producer, so its bit is forced low last.
    always_comb begin
        pendingNext = pending;
        if (iFlush) begin
            pendingNext = '0;
        end else begin
            for (int r = 0; r < N_REGS; r++) begin
                if (iRsvEn && (iRsvAddr == ADDR_WIDTH'(r))) begin
                    pendingNext[r] = 1'b1;
                end else if (iClrMask[r]) begin
                    pendingNext[r] = 1'b0;
                end
            end
        end
        pendingNext[0] = 1'b0;
    end

    // Pending bit register; reset drops every outstanding reservation.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    assign oPendingMask = pending;

endmodule : reg_scoreboard

// File: rtl/reg_file_mp.sv
// reg_file_mp
// Multi-port RV32 integer register file with write-pending scoreboard and
// optional same-cycle write-to-read bypass. x0 reads zero and is never pending.
// Ports:
//   iClk         : clock, all state updates on the rising edge
//   iRst         : asynchronous active-high reset
//   iWr          : per write port {addr, value}
//   iWrEn        : per write port enable
//   iRdAddr      : per read port register address
//   oRdData      : per read port data (combinational)
//   oRdReady     : per read port, 1 = addressed register has no outstanding producer
//   iRsvEn       : reserve a destination register
//   iRsvAddr     : register to mark pending
//   iFlush       : clear all pending bits
//   oPendingMask : current pending bits
module reg_file_mp
    import rv32_isa::*;
    import reg_transport::*;
#(
    parameter int N_REGS     = 32,
    parameter int REG_WIDTH  = RegWidth,
    parameter int ADDR_WIDTH = RegAddrWidth,
    parameter int N_READ     = 2,
    parameter int N_WRITE    = 1,
    parameter int BYPASS     = 1
) (
    input  logic                                iClk,
    input  logic                                iRst,
    input  reg_transport_t [N_WRITE-1:0]        iWr,
    input  logic [N_WRITE-1:0]                  iWrEn,
    input  logic [N_READ-1:0][ADDR_WIDTH-1:0]   iRdAddr,
    output logic [N_READ-1:0][REG_WIDTH-1:0]    oRdData,
    output logic [N_READ-1:0]                   oRdReady,
    input  logic                                iRsvEn,
    input  logic [ADDR_WIDTH-1:0]               iRsvAddr,
    input  logic                                iFlush,
    output logic [N_REGS-1:0]                   oPendingMask
);

    // Elaboration-time sanity checks. The transport struct has fixed field
    // widths, so the data and address widths must also match it.
    initial begin
        if (ADDR_WIDTH != $clog2(N_REGS))
            $fatal(1, "reg_file_mp: ADDR_WIDTH %0d does not match N_REGS %0d", ADDR_WIDTH, N_REGS);
        if (ADDR_WIDTH != RegAddrWidth || REG_WIDTH != RegWidth)
            $fatal(1, "reg_file_mp: widths must match reg_transport_t fields");
        if (N_READ < 1 || N_READ > MaxReadPorts)
            $fatal(1, "reg_file_mp: N_READ %0d out of range", N_READ);
        if (N_WRITE < 1 || N_WRITE > MaxWritePorts)
            $fatal(1, "reg_file_mp: N_WRITE %0d out of range", N_WRITE);
    end

    logic [REG_WIDTH-1:0] regs [N_REGS];
    logic [N_REGS-1:0]    wrHit;
    logic [N_REGS-1:0]    pendingMask;

    // One bit per register that some enabled write port targets this cycle.
    // Feeds the scoreboard so a retiring write clears its pending bit.
    always_comb begin
        wrHit = '0;
        for (int p = 0; p < N_WRITE; p++) begin
            if (iWrEn[p]) begin
                wrHit[iWr[p].addr] = 1'b1;
            end
        end
    end

    // Data array. Ports are scanned low to high so the highest-indexed port
    // targeting a register is the last assignment and therefore wins.
    // Entry 0 is never written, which keeps x0 at zero.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int r = 0; r < N_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < N_REGS; r++) begin
                for (int p = 0; p < N_WRITE; p++) begin
                    if (iWrEn[p] && (iWr[p].addr == ADDR_WIDTH'(r))) begin
                        regs[r] <= iWr[p].value;
                    end
                end
            end
        end
    end

    // Read ports. With bypass enabled, a same-cycle write to the read address
    // supplies the data and also makes the port ready, since that write is the
    // producer being waited on. A same-cycle reserve is not visible here; it
    // only shows up once the scoreboard has registered it.
    always_comb begin
        oRdData  = '0;
        oRdReady = '1;
        for (int i = 0; i < N_READ; i++) begin
            if (iRdAddr[i] != '0) begin
                oRdData[i]  = regs[iRdAddr[i]];
                oRdReady[i] = ~pendingMask[iRdAddr[i]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < N_WRITE; p++) begin
                        if (iWrEn[p] && (iWr[p].addr == iRdAddr[i])) begin
                            oRdData[i]  = iWr[p].value;
                            oRdReady[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    reg_scoreboard #(
        .N_REGS     (N_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .iClk         (iClk),
        .iRst         (iRst),
        .iFlush       (iFlush),
        .iRsvEn       (iRsvEn),
        .iRsvAddr     (iRsvAddr),
        .iClrMask     (wrHit),
        .oPendingMask (pendingMask)
    );

    assign oPendingMask = pendingMask;

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp
// Directed vector bench for reg_file_mp: a bypassing two-write instance driven
// from a table, plus a non-bypassing instance on the same inputs exercised by
// hand-written sequences for registered-read and mid-cycle reset behaviour.
module tb_reg_file_mp;

    import reg_transport::*;

    typedef struct {
        logic [1:0]  wrEn;
        logic [4:0]  wa0;
        logic [31:0] wv0;
        logic [4:0]  wa1;
        logic [31:0] wv1;
        logic        rsvEn;
        logic [4:0]  rsvAddr;
        logic        flush;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic [1:0]  eRdy;
        logic [31:0] eMask;
    } vec_t;

    logic                   clk;
    logic                   rst;
    reg_transport_t [1:0]   wr;
    logic [1:0]             wrEn;
    logic [1:0][4:0]        rdAddr;
    logic [1:0][31:0]       rdData;
    logic [1:0]             rdReady;
    logic [1:0][31:0]       rdDataNb;
    logic [1:0]             rdReadyNb;
    logic                   rsvEn;
    logic [4:0]             rsvAddr;
    logic                   flush;
    logic [31:0]            pendingMask;
    logic [31:0]            pendingMaskNb;

    int vecCount = 0;
    int errCount = 0;

    vec_t vecs [18];

    reg_file_mp #(
        .N_REGS (32), .N_READ (2), .N_WRITE (2), .BYPASS (1)
    ) dut (
        .iClk (clk), .iRst (rst), .iWr (wr), .iWrEn (wrEn),
        .iRdAddr (rdAddr), .oRdData (rdData), .oRdReady (rdReady),
        .iRsvEn (rsvEn), .iRsvAddr (rsvAddr), .iFlush (flush),
        .oPendingMask (pendingMask)
    );

    reg_file_mp #(
        .N_REGS (32), .N_READ (2), .N_WRITE (2), .BYPASS (0)
    ) dutNb (
        .iClk (clk), .iRst (rst), .iWr (wr), .iWrEn (wrEn),
        .iRdAddr (rdAddr), .oRdData (rdDataNb), .oRdReady (rdReadyNb),
        .iRsvEn (rsvEn), .iRsvAddr (rsvAddr), .iFlush (flush),
        .oPendingMask (pendingMaskNb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] v0,
                                input logic [4:0] a1, input logic [31:0] v1,
                                input logic re, input logic [4:0] ra, input logic fl,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] rdy, input logic [31:0] m);
        vec_t v;
        v.wrEn = we; v.wa0 = a0; v.wv0 = v0; v.wa1 = a1; v.wv1 = v1;
        v.rsvEn = re; v.rsvAddr = ra; v.flush = fl;
        v.ra0 = r0; v.ra1 = r1; v.ed0 = d0; v.ed1 = d1; v.eRdy = rdy; v.eMask = m;
        return v;
    endfunction

    // Drive one vector's inputs onto both instances.
    task automatic applyStimulus(input vec_t v);
        wrEn          = v.wrEn;
        wr[0].addr    = v.wa0;
        wr[0].value   = v.wv0;
        wr[1].addr    = v.wa1;
        wr[1].value   = v.wv1;
        rsvEn         = v.rsvEn;
        rsvAddr       = v.rsvAddr;
        flush         = v.flush;
        rdAddr[0]     = v.ra0;
        rdAddr[1]     = v.ra1;
    endtask

    // Compare one value and count it.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(mk(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
                         5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 32'h0));
    endtask

    initial begin
        // wrEn   a0     v0            a1     v1     rsv   rA     fl    r0     r1     d0            d1            rdy    mask
        vecs[0]  = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  32'h0,        32'h0,        2'b11, 32'h0);
        vecs[1]  = mk(2'b01, 5'd7, 32'hDEADBEEF, 5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd7,  5'd5,  32'hDEADBEEF, 32'h0,        2'b11, 32'h0);
        vecs[2]  = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        2'b11, 32'h0);
        vecs[3]  = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b1, 5'd3,  1'b0, 5'd3,  5'd7,  32'h0,        32'hDEADBEEF, 2'b11, 32'h0);
        vecs[4]  = mk(2'b01, 5'd3, 32'h12,       5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd3,  5'd3,  32'h12,       32'h12,       2'b11, 32'h8);
        vecs[5]  = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd3,  5'd7,  32'h12,       32'hDEADBEEF, 2'b11, 32'h0);
        vecs[6]  = mk(2'b01, 5'd9, 32'h55,       5'd0,  32'h0,  1'b1, 5'd9,  1'b0, 5'd9,  5'd0,  32'h55,       32'h0,        2'b11, 32'h0);
        vecs[7]  = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd9,  5'd0,  32'h55,       32'h0,        2'b10, 32'h200);
        vecs[8]  = mk(2'b11, 5'd4, 32'h1,        5'd4,  32'h2,  1'b0, 5'd0,  1'b0, 5'd4,  5'd9,  32'h2,        32'h55,       2'b01, 32'h200);
        vecs[9]  = mk(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0,  32'h77, 1'b0, 5'd0,  1'b0, 5'd0,  5'd4,  32'h0,        32'h2,        2'b11, 32'h200);
        vecs[10] = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd0,  5'd4,  32'h0,        32'h2,        2'b11, 32'h200);
        vecs[11] = mk(2'b11, 5'd9, 32'hA5,       5'd12, 32'h33, 1'b0, 5'd0,  1'b0, 5'd9,  5'd12, 32'hA5,       32'h33,       2'b11, 32'h200);
        vecs[12] = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd9,  5'd12, 32'hA5,       32'h33,       2'b11, 32'h0);
        vecs[13] = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b1, 5'd1,  1'b0, 5'd1,  5'd2,  32'h0,        32'h0,        2'b11, 32'h0);
        vecs[14] = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b1, 5'd2,  1'b0, 5'd1,  5'd2,  32'h0,        32'h0,        2'b10, 32'h2);
        vecs[15] = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b1, 5'd10, 1'b0, 5'd2,  5'd10, 32'h0,        32'h0,        2'b10, 32'h6);
        vecs[16] = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b1, 5'd11, 1'b1, 5'd10, 5'd11, 32'h0,        32'h0,        2'b10, 32'h406);
        vecs[17] = mk(2'b00, 5'd0, 32'h0,        5'd0,  32'h0,  1'b0, 5'd0,  1'b0, 5'd10, 5'd11, 32'h0,        32'h0,        2'b11, 32'h0);

        rst = 1'b1;
        idle();
        rdAddr[0] = 5'd5;
        #2;
        checkOutput("reset.data0", rdData[0], 32'h0);
        checkOutput("reset.ready", {30'h0, rdReady}, 32'h3);
        checkOutput("reset.mask", pendingMask, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors: inputs driven at the falling edge, outputs sampled
        // 1 time unit later, state advances on the following rising edge.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.data0", i), rdData[0], vecs[i].ed0);
            checkOutput($sformatf("v%0d.data1", i), rdData[1], vecs[i].ed1);
            checkOutput($sformatf("v%0d.ready", i), {30'h0, rdReady}, {30'h0, vecs[i].eRdy});
            checkOutput($sformatf("v%0d.mask", i), pendingMask, vecs[i].eMask);
        end

        // Registered reads without bypass: data appears one cycle after the write
        // and readiness follows the registered pending bit only.
        @(negedge clk);
        idle();
        wrEn = 2'b01; wr[0].addr = 5'd13; wr[0].value = 32'h00000BEE; rdAddr[0] = 5'd13;
        #1;
        checkOutput("nb.write.old", rdDataNb[0], 32'h0);
        checkOutput("nb.write.bypass", rdData[0], 32'h00000BEE);
        @(negedge clk);
        idle();
        rsvEn = 1'b1; rsvAddr = 5'd13; rdAddr[0] = 5'd13;
        #1;
        checkOutput("nb.stored", rdDataNb[0], 32'h00000BEE);
        @(negedge clk);
        idle();
        wrEn = 2'b01; wr[0].addr = 5'd13; wr[0].value = 32'h0000C0DE; rdAddr[0] = 5'd13;
        #1;
        checkOutput("nb.pend.ready", {31'h0, rdReadyNb[0]}, 32'h0);
        checkOutput("nb.pend.data", rdDataNb[0], 32'h00000BEE);
        checkOutput("byp.pend.ready", {31'h0, rdReady[0]}, 32'h1);
        checkOutput("byp.pend.data", rdData[0], 32'h0000C0DE);
        checkOutput("nb.pend.mask", pendingMaskNb, 32'h00002000);
        @(negedge clk);
        idle();
        rdAddr[0] = 5'd13;
        #1;
        checkOutput("nb.after.data", rdDataNb[0], 32'h0000C0DE);
        checkOutput("nb.after.ready", {31'h0, rdReadyNb[0]}, 32'h1);
        checkOutput("nb.after.mask", pendingMaskNb, 32'h0);

        // Reset asserted in the middle of a cycle carrying a write.
        @(negedge clk);
        idle();
        rsvEn = 1'b1; rsvAddr = 5'd5;
        @(negedge clk);
        idle();
        wrEn = 2'b01; wr[0].addr = 5'd20; wr[0].value = 32'h0000CAFE;
        rdAddr[0] = 5'd5; rdAddr[1] = 5'd7;
        #1;
        checkOutput("prerst.mask", pendingMask, 32'h00000020);
        checkOutput("prerst.data1", rdData[1], 32'hDEADBEEF);
        checkOutput("prerst.ready", {30'h0, rdReady}, 32'h2);
        rst = 1'b1;
        #1;
        checkOutput("rst.mask", pendingMask, 32'h0);
        checkOutput("rst.data1", rdData[1], 32'h0);
        checkOutput("rst.ready", {30'h0, rdReady}, 32'h3);
        @(negedge clk);
        rst = 1'b0;
        idle();
        rdAddr[0] = 5'd20; rdAddr[1] = 5'd13;
        #1;
        checkOutput("postrst.data0", rdData[0], 32'h0);
        checkOutput("postrst.data1", rdData[1], 32'h0);
        checkOutput("postrst.nb.data1", rdDataNb[1], 32'h0);
        checkOutput("postrst.mask", pendingMask, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule : tb_reg_file_mp

// File: doc/reg_file_mp.md
# reg_file_mp

Multi-port RV32 integer register file with an integrated write-pending scoreboard and same-cycle write-to-read bypass. It is the parametrised successor to the single-write, dual-read register file. It sits between decode/issue and writeback in the core pipeline. Issue uses per-read-port ready flags to detect RAW hazards. Writeback retires results through one or more write ports. Register x0 is hardwired to zero and never pending.

## Interface
Parameters:
- N_REGS, 32, number of architectural registers; x0 included; power of two ≥ 2
- REG_WIDTH, rv32_isa::RegWidth (32), data width
- ADDR_WIDTH, rv32_isa::RegAddrWidth (5), register address width; must equal $clog2(N_REGS)
- N_READ, 2, read port count, 1..4
- N_WRITE, 1, write port count, 1..2
- BYPASS, 1, 1 = read ports see same-cycle write data; 0 = reads return stored value only

Ports:
- iClk  in  1  clock; all state updates on rising edge
- iRst  in  1  reset, asynchronous, active-high
- iWr  in  N_WRITE × reg_transport_t  per-port write address and value
- iWrEn  in  N_WRITE  per-port write enable
- iRdAddr  in  N_READ × ADDR_WIDTH  read addresses
- oRdData  out  N_READ × REG_WIDTH  read data
- oRdReady  out  N_READ  1 = addressed register has no outstanding producer
- iRsvEn  in  1  issue reserves a destination register
- iRsvAddr  in  ADDR_WIDTH  destination register to mark pending
- iFlush  in  1  clear all pending bits (pipeline squash)
- oPendingMask  out  N_REGS  current pending bits; bit 0 is always 0

## Operation
- Storage: N_REGS-1 registers plus a constant-zero x0. Writes to address 0 are discarded.
- Write priority: if several write ports target the same address in one cycle, the highest-indexed port wins.
- Pending bits, evaluated per register at each edge:
  - iFlush clears all bits; any same-cycle reserve is ignored.
  - Otherwise, a reserve of register r sets bit r.
  - Otherwise, any enabled write to r clears bit r.
- Reserve and write to the same register in one cycle: reserve wins and the bit stays 1, because the newer producer owns the register. The write data is still stored.
- Reserving an already-pending register keeps the bit at 1. There is no counting and no error.
- Read data with BYPASS=1: if an enabled write targets the read address (non-zero), return that write's data, using the same priority rule. Otherwise return the stored value.
- oRdReady with BYPASS=1: the port is ready when its pending bit is 0, or when a same-cycle enabled write targets its address. A same-cycle reserve does not lower oRdReady until the following cycle.
- BYPASS=0: oRdData and oRdReady come from registered state only.
- Address 0 always reads 0 with oRdReady=1.

## Timing
- Reset: all registers 0, all pending bits 0. Therefore oRdData=0, oRdReady=all 1s, and oPendingMask=0 immediately, without waiting for a clock edge.
- Reads are combinational, with zero-cycle latency from address (and, under BYPASS, from write inputs).
- Writes, reserves and flushes take effect at the next rising edge. Stored data is visible one cycle later when BYPASS=0.
- iRst asserted mid-operation discards in-flight reserves and writes in that cycle. After deassertion the state is the reset state.
- No handshake back-pressure: every write and reserve is accepted in the cycle it is presented.

## Structure
- The reg_transport package holds reg_transport_t (addr: ADDR_WIDTH, value: REG_WIDTH), which already exists. It gains localparam MaxReadPorts=4 and MaxWritePorts=2.
- rv32_isa supplies RegWidth and RegAddrWidth.
- One sub-module, reg_scoreboard: it owns the N_REGS pending bits and applies flush/reserve/clear priority. Its outputs are the pending mask only.
- The top level holds the data array, write-priority muxing and the bypass/ready logic.
- Parameter checks go in an initial block using $fatal: ADDR_WIDTH matches N_REGS, and port counts are in range.

## Test plan
- Reset, then read x5 and x0 → both oRdData=0, oRdReady=1; oPendingMask=0.
- Write x7=0xDEADBEEF on port 0 with BYPASS=1 → same cycle, a read of x7 returns 0xDEADBEEF. Next cycle, with no write, it still returns 0xDEADBEEF.
- Reserve x3 → next cycle oRdReady for x3 is 0 and oPendingMask[3]=1. Write x3=0x12 → same cycle oRdReady=1 with data 0x12; next cycle mask bit 3 is 0.
- Same cycle: reserve x9 and write x9=0x55 → next cycle x9 reads 0x55 with oRdReady=0 (the bit stays pending).
- N_WRITE=2, both ports write x4 (port 0 = 0x1, port 1 = 0x2) → x4 reads 0x2. Any write to x0 → x0 still reads 0.
- Reserve x1, x2 and x10 over three cycles, then assert iFlush together with a reserve of x11 → oPendingMask=0 after the edge. Then assert iRst mid-write → all registers read 0.
